// File: rtl/wb_crossbar_rr.sv
// Shared-bus Wishbone B4 pipelined interconnect with round-robin arbitration and base/mask decode.
// Latency: 1 cycle to arbitrate; slave responses are forwarded combinationally in the same cycle.
// Backpressure: the granted master sees the decoded slave's stall; every other master sees stall=1.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   m_*_i / m_*_o                 NUM_MASTERS flattened master ports (cyc, stb, we, adr, dat, sel / stall, ack, err, dat)
//   s_cyc_o, s_stb_o              per-slave cycle and strobe
//   s_we_o, s_adr_o, s_dat_o,
//   s_sel_o                       shared request fields from the granted master
//   s_stall_i, s_ack_i, s_err_i,
//   s_dat_i                       per-slave responses
//   grant_o                       one-hot current grant (status)
//   timeout_o                     one-cycle pulse when the response watchdog fires
module wb_crossbar_rr #(
    parameter int                        NUM_MASTERS = 2,
    parameter int                        NUM_SLAVES  = 5,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE  = '0,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK  = '0,
    parameter int                        TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [32*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [32*NUM_MASTERS-1:0]   m_dat_i,
    input  logic [4*NUM_MASTERS-1:0]    m_sel_i,
    output logic [NUM_MASTERS-1:0]      m_stall_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [32*NUM_MASTERS-1:0]   m_dat_o,
    output logic [NUM_SLAVES-1:0]       s_cyc_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    output logic                        s_we_o,
    output logic [31:0]                 s_adr_o,
    output logic [31:0]                 s_dat_o,
    output logic [3:0]                  s_sel_o,
    input  logic [NUM_SLAVES-1:0]       s_stall_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic [NUM_SLAVES-1:0]       s_err_i,
    input  logic [32*NUM_SLAVES-1:0]    s_dat_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int          MW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int          SW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam bit          TMO_EN   = (TIMEOUT > 0);
    localparam logic [15:0] TMO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          gidx_q, gidx_d;
    logic [MW-1:0]          rr_q, rr_d;
    logic [15:0]            timer_q, timer_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic                   dflt_q, dflt_d;

    // Granted master's request fields
    logic        g_cyc, g_stb, g_we;
    logic [31:0] g_adr, g_dat;
    logic [3:0]  g_sel;

    // Address decode and response selection
    logic          hit_any;
    logic [SW-1:0] hit_idx;
    logic          win_stall;
    logic          sel_ack, sel_err;
    logic [31:0]   sel_dat;

    // WAIT-state response qualification
    logic          wait_ack, wait_err, wait_tmo;
    logic [31:0]   wait_dat;

    // Arbitration
    logic [NUM_MASTERS-1:0] req;
    logic                   arb_found;
    logic [MW-1:0]          arb_idx;
    logic [MW-1:0]          rr_next;

    // Per-cycle values destined for the granted master
    logic        g_stall_o, g_ack_o, g_err_o;
    logic [31:0] g_dat_o;

    assign req     = m_cyc_i & m_stb_i;
    assign rr_next = (gidx_q == MW'(NUM_MASTERS - 1)) ? '0 : gidx_q + MW'(1);
    assign grant_o = grant_q;

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gidx_q == MW'(i)) begin
                g_cyc = m_cyc_i[i];
                g_stb = m_stb_i[i];
                g_we  = m_we_i[i];
                g_adr = m_adr_i[32*i +: 32];
                g_dat = m_dat_i[32*i +: 32];
                g_sel = m_sel_i[4*i +: 4];
            end
        end
    end

    // Scan downwards so the lowest-index hitting slave is the last one written.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((g_adr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
                hit_any = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    always_comb begin
        win_stall = 1'b0;
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        sel_dat   = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (hit_idx == SW'(k)) begin
                win_stall = s_stall_i[k];
            end
            if (sel_q == SW'(k)) begin
                sel_ack = s_ack_i[k];
                sel_err = s_err_i[k];
                sel_dat = s_dat_i[32*k +: 32];
            end
        end
    end

    // Round robin without modulo indexing: prefer the lowest requester at or
    // above the pointer, otherwise wrap to the lowest requester overall.
    always_comb begin
        logic          upper_found;
        logic [MW-1:0] upper_idx;
        logic          lower_found;
        logic [MW-1:0] lower_idx;
        upper_found = 1'b0;
        upper_idx   = '0;
        lower_found = 1'b0;
        lower_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lower_found = 1'b1;
                lower_idx   = MW'(i);
                if (MW'(i) >= rr_q) begin
                    upper_found = 1'b1;
                    upper_idx   = MW'(i);
                end
            end
        end
        arb_found = lower_found;
        arb_idx   = upper_found ? upper_idx : lower_idx;
    end

    // The default slave answers on the first WAIT cycle; a real slave's
    // response is only honoured while the master still holds its cycle,
    // so an ack arriving after an abort never reaches anyone.
    always_comb begin
        wait_ack = 1'b0;
        wait_err = 1'b0;
        wait_tmo = 1'b0;
        wait_dat = '0;
        if (state_q == ST_WAIT && g_cyc) begin
            if (dflt_q) begin
                wait_err = 1'b1;
            end else if (sel_err) begin
                wait_err = 1'b1;
                wait_dat = sel_dat;
            end else if (sel_ack) begin
                wait_ack = 1'b1;
                wait_dat = sel_dat;
            end else if (TMO_EN && timer_q == TMO_LAST) begin
                wait_err = 1'b1;
                wait_tmo = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        dflt_d  = dflt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d = ST_GRANT;
                    gidx_d  = arb_idx;
                    grant_d = NUM_MASTERS'(1) << arb_idx;
                end
            end
            ST_GRANT: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rr_d    = rr_next;
                end else if (g_stb) begin
                    if (!hit_any) begin
                        state_d = ST_WAIT;
                        dflt_d  = 1'b1;
                        timer_d = '0;
                    end else if (!win_stall) begin
                        state_d = ST_WAIT;
                        sel_d   = hit_idx;
                        dflt_d  = 1'b0;
                        timer_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rr_d    = rr_next;
                    dflt_d  = 1'b0;
                end else if (wait_ack || wait_err) begin
                    state_d = ST_GRANT;
                    dflt_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            timer_q <= '0;
            sel_q   <= '0;
            dflt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            dflt_q  <= dflt_d;
        end
    end

    always_comb begin
        g_stall_o = 1'b1;
        g_ack_o   = 1'b0;
        g_err_o   = 1'b0;
        g_dat_o   = '0;
        s_cyc_o   = '0;
        s_stb_o   = '0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        timeout_o = 1'b0;
        if (state_q == ST_GRANT) begin
            s_we_o    = g_we;
            s_adr_o   = g_adr;
            s_dat_o   = g_dat;
            s_sel_o   = g_sel;
            // An unmapped address is swallowed by the default slave, which never stalls.
            g_stall_o = hit_any ? win_stall : 1'b0;
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (hit_any && hit_idx == SW'(k)) begin
                    s_cyc_o[k] = g_cyc;
                    s_stb_o[k] = g_stb;
                end
            end
        end else if (state_q == ST_WAIT) begin
            s_we_o    = g_we;
            s_adr_o   = g_adr;
            s_dat_o   = g_dat;
            s_sel_o   = g_sel;
            g_ack_o   = wait_ack;
            g_err_o   = wait_err;
            g_dat_o   = wait_dat;
            timeout_o = wait_tmo;
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (!dflt_q && sel_q == SW'(k)) begin
                    s_cyc_o[k] = g_cyc;
                end
            end
        end
    end

    always_comb begin
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_dat_o   = '0;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (gidx_q == MW'(i)) begin
                    m_stall_o[i]         = g_stall_o;
                    m_ack_o[i]           = g_ack_o;
                    m_err_o[i]           = g_err_o;
                    m_dat_o[32*i +: 32]  = g_dat_o;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_crossbar_rr.sv
// Directed bench for wb_crossbar_rr: two masters, five slaves, watchdog of 8 cycles.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Slave responses are driven by hand per scenario.
module tb_wb_crossbar_rr;

    logic         wb_clk_i;
    logic         wb_rst_i;
    logic [1:0]   m_cyc_i, m_stb_i, m_we_i;
    logic [63:0]  m_adr_i, m_dat_i;
    logic [7:0]   m_sel_i;
    logic [1:0]   m_stall_o, m_ack_o, m_err_o;
    logic [63:0]  m_dat_o;
    logic [4:0]   s_cyc_o, s_stb_o;
    logic         s_we_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic [4:0]   s_stall_i, s_ack_i, s_err_i;
    logic [159:0] s_dat_i;
    logic [1:0]   grant_o;
    logic         timeout_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave map: s0 0x0xxx, s1 0x1xxx, s2 0x2xxx, s3 0x8010..0x8013,
    // s4 0x8000..0x8FFF (overlaps s3; s3 must win).
    wb_crossbar_rr #(
        .NUM_MASTERS (2),
        .NUM_SLAVES  (5),
        .SLAVE_BASE  ({32'h0000_8000, 32'h0000_8010, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLAVE_MASK  ({32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT     (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_stall_o (m_stall_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_stall_i (s_stall_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_dat_i   (s_dat_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic step;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        m_cyc_i   = '0;
        m_stb_i   = '0;
        m_we_i    = '0;
        m_adr_i   = '0;
        m_dat_i   = '0;
        m_sel_i   = '0;
        s_stall_i = '0;
        s_ack_i   = '0;
        s_err_i   = '0;
        s_dat_i   = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        wb_rst_i = 1'b1;
        step();
        step();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        n_cmp++; if (m_stall_o !== 2'b11) begin n_fail++; $display("FAIL reset_stall: got %b want 11", m_stall_o); end
        n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        n_cmp++; if ({m_ack_o, m_err_o, s_cyc_o, s_stb_o, timeout_o} !== 15'd0) begin
            n_fail++; $display("FAIL reset_ctl: ack %b err %b cyc %b stb %b tmo %b want all 0", m_ack_o, m_err_o, s_cyc_o, s_stb_o, timeout_o);
        end
        step();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_single_read;
        int stb3_cycles;
        stb3_cycles = 0;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b0;
        m_adr_i[31:0] = 32'h0000_8010; m_sel_i[3:0] = 4'hF;
        s_dat_i[127:96] = 32'hA5A5_0001;
        @(negedge wb_clk_i);   // IDLE: arbitration cycle
        n_cmp++; if (m_stall_o[0] !== 1'b1) begin n_fail++; $display("FAIL rd_idle_stall: got %b want 1", m_stall_o[0]); end
        if (s_stb_o[3]) stb3_cycles++;
        step();
        @(negedge wb_clk_i);   // GRANT: accepted this cycle
        n_cmp++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL rd_grant: got %b want 01", grant_o); end
        n_cmp++; if (s_cyc_o !== 5'b01000) begin n_fail++; $display("FAIL rd_cyc: got %b want 01000", s_cyc_o); end
        n_cmp++; if (m_stall_o !== 2'b10) begin n_fail++; $display("FAIL rd_grant_stall: got %b want 10", m_stall_o); end
        n_cmp++; if (s_adr_o !== 32'h0000_8010) begin n_fail++; $display("FAIL rd_adr: got %h want 00008010", s_adr_o); end
        if (s_stb_o[3]) stb3_cycles++;
        step();
        m_stb_i[0] = 1'b0;
        @(negedge wb_clk_i);   // WAIT, 1 cycle after accept
        n_cmp++; if (s_cyc_o !== 5'b01000) begin n_fail++; $display("FAIL rd_wait_cyc: got %b want 01000", s_cyc_o); end
        n_cmp++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rd_early_ack: got %b want 00", m_ack_o); end
        if (s_stb_o[3]) stb3_cycles++;
        step();
        s_ack_i[3] = 1'b1;
        @(negedge wb_clk_i);   // WAIT, 2 cycles after accept: ack forwarded
        n_cmp++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got %b want 01", m_ack_o); end
        n_cmp++; if (m_dat_o[31:0] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd_dat: got %h want a5a50001", m_dat_o[31:0]); end
        n_cmp++; if (m_dat_o[63:32] !== 32'h0) begin n_fail++; $display("FAIL rd_dat_other: got %h want 0", m_dat_o[63:32]); end
        if (s_stb_o[3]) stb3_cycles++;
        step();
        s_ack_i[3] = 1'b0;
        m_cyc_i[0] = 1'b0;
        @(negedge wb_clk_i);   // GRANT with cyc low
        n_cmp++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rd_ack_len: got %b want 00", m_ack_o); end
        if (s_stb_o[3]) stb3_cycles++;
        step();
        @(negedge wb_clk_i);
        n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL rd_release: got %b want 00", grant_o); end
        n_cmp++; if (stb3_cycles !== 1) begin n_fail++; $display("FAIL rd_stb_cycles: got %0d want 1", stb3_cycles); end
        step();
        clear_inputs();
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g;
        do_reset();
        m_adr_i  = {32'h0000_0100, 32'h0000_0100};
        m_sel_i  = 8'hFF;
        s_dat_i[31:0] = 32'hCAFE_0000;
        for (int r = 0; r < 4; r++) begin
            int g;
            g = r % 2;
            exp_g = 2'b01 << g;
            m_cyc_i = 2'b11;
            m_stb_i = 2'b11;
            @(negedge wb_clk_i);   // IDLE
            step();
            @(negedge wb_clk_i);   // GRANT
            n_cmp++; if (grant_o !== exp_g) begin n_fail++; $display("FAIL rr_grant round %0d: got %b want %b", r, grant_o, exp_g); end
            n_cmp++; if (m_stall_o !== ~exp_g) begin n_fail++; $display("FAIL rr_stall round %0d: got %b want %b", r, m_stall_o, ~exp_g); end
            step();
            m_stb_i[g] = 1'b0;
            s_ack_i[0] = 1'b1;
            @(negedge wb_clk_i);   // WAIT: ack
            n_cmp++; if (m_ack_o !== exp_g) begin n_fail++; $display("FAIL rr_ack round %0d: got %b want %b", r, m_ack_o, exp_g); end
            step();
            s_ack_i[0] = 1'b0;
            m_cyc_i[g] = 1'b0;
            @(negedge wb_clk_i);   // GRANT -> IDLE
            step();
        end
        clear_inputs();
    endtask

    task automatic test_unmapped;
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b1;
        m_adr_i[63:32] = 32'hFFFF_0000; m_dat_i[63:32] = 32'h1234_5678; m_sel_i[7:4] = 4'b0011;
        @(negedge wb_clk_i);   // IDLE
        step();
        @(negedge wb_clk_i);   // GRANT
        n_cmp++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL um_grant: got %b want 10", grant_o); end
        n_cmp++; if (m_stall_o !== 2'b01) begin n_fail++; $display("FAIL um_stall: got %b want 01", m_stall_o); end
        n_cmp++; if ({s_cyc_o, s_stb_o} !== 10'd0) begin n_fail++; $display("FAIL um_slave_req: cyc %b stb %b want 0", s_cyc_o, s_stb_o); end
        n_cmp++; if ({s_we_o, s_dat_o, s_sel_o} !== {1'b1, 32'h1234_5678, 4'b0011}) begin
            n_fail++; $display("FAIL um_fields: we %b dat %h sel %b want 1 12345678 0011", s_we_o, s_dat_o, s_sel_o);
        end
        step();
        m_stb_i[1] = 1'b0;
        @(negedge wb_clk_i);   // WAIT: default-slave error
        n_cmp++; if ({m_err_o, m_ack_o} !== 4'b1000) begin n_fail++; $display("FAIL um_err: err %b ack %b want 10 00", m_err_o, m_ack_o); end
        n_cmp++; if (s_stb_o !== 5'd0) begin n_fail++; $display("FAIL um_wait_stb: got %b want 0", s_stb_o); end
        step();
        m_cyc_i[1] = 1'b0;
        @(negedge wb_clk_i);
        n_cmp++; if (m_err_o !== 2'b00) begin n_fail++; $display("FAIL um_err_len: got %b want 00", m_err_o); end
        step();
        clear_inputs();
    endtask

    task automatic test_timeout;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        m_adr_i[31:0] = 32'h0000_2004; m_sel_i[3:0] = 4'hF;
        @(negedge wb_clk_i);   // IDLE
        step();
        @(negedge wb_clk_i);   // GRANT: accept
        n_cmp++; if (s_stb_o !== 5'b00100) begin n_fail++; $display("FAIL to_stb: got %b want 00100", s_stb_o); end
        step();
        m_stb_i[0] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge wb_clk_i);
            if (j < 8) begin
                if ({m_err_o, timeout_o} !== 3'b000 || s_cyc_o !== 5'b00100) begin
                    n_fail++; $display("FAIL to_early cycle %0d: err %b tmo %b cyc %b want 00 0 00100", j, m_err_o, timeout_o, s_cyc_o);
                end
                n_cmp++;
            end else begin
                n_cmp++; if ({m_err_o, timeout_o} !== 3'b011) begin n_fail++; $display("FAIL to_fire: err %b tmo %b want 01 1", m_err_o, timeout_o); end
            end
            step();
        end
        m_cyc_i[0] = 1'b0;
        @(negedge wb_clk_i);
        n_cmp++; if ({s_cyc_o, timeout_o} !== 6'd0) begin n_fail++; $display("FAIL to_cyc_drop: cyc %b tmo %b want 0", s_cyc_o, timeout_o); end
        step();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        m_adr_i[31:0] = 32'h0000_0100;
        @(negedge wb_clk_i);   // IDLE
        step();
        @(negedge wb_clk_i);
        n_cmp++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL to_regrant: got %b want 01", grant_o); end
        step();
        clear_inputs();        // aborts the accepted access in WAIT
        step();
    endtask

    task automatic test_stall_ack_err;
        s_stall_i[1] = 1'b1;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        m_adr_i[31:0] = 32'h0000_1008; m_sel_i[3:0] = 4'hF;
        s_dat_i[63:32] = 32'h0BAD_0BAD;
        @(negedge wb_clk_i);   // IDLE
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge wb_clk_i);
            n_cmp++; if (m_stall_o[0] !== 1'b1 || s_stb_o !== 5'b00010) begin
                n_fail++; $display("FAIL st_stall cycle %0d: stall %b stb %b want 1 00010", c, m_stall_o[0], s_stb_o);
            end
            step();
        end
        s_stall_i[1] = 1'b0;
        @(negedge wb_clk_i);
        n_cmp++; if (m_stall_o[0] !== 1'b0) begin n_fail++; $display("FAIL st_release: got %b want 0", m_stall_o[0]); end
        step();
        m_stb_i[0] = 1'b0;
        s_ack_i[1] = 1'b1; s_err_i[1] = 1'b1;
        @(negedge wb_clk_i);
        n_cmp++; if ({m_err_o, m_ack_o} !== 4'b0100) begin n_fail++; $display("FAIL st_err_wins: err %b ack %b want 01 00", m_err_o, m_ack_o); end
        step();
        s_ack_i[1] = 1'b0; s_err_i[1] = 1'b0;
        m_cyc_i[0] = 1'b0;
        @(negedge wb_clk_i);
        step();
        clear_inputs();
    endtask

    task automatic test_abort_and_reset;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        m_adr_i[31:0] = 32'h0000_8010; m_sel_i[3:0] = 4'hF;
        @(negedge wb_clk_i);   // IDLE
        step();
        @(negedge wb_clk_i);   // GRANT: accept
        step();
        m_stb_i[0] = 1'b0;
        @(negedge wb_clk_i);   // WAIT
        n_cmp++; if (s_cyc_o !== 5'b01000) begin n_fail++; $display("FAIL ab_wait_cyc: got %b want 01000", s_cyc_o); end
        step();
        m_cyc_i[0] = 1'b0;
        @(negedge wb_clk_i);   // abort
        n_cmp++; if (s_cyc_o !== 5'd0) begin n_fail++; $display("FAIL ab_cyc_drop: got %b want 0", s_cyc_o); end
        step();
        @(negedge wb_clk_i);
        step();
        s_ack_i[3] = 1'b1;
        @(negedge wb_clk_i);   // late ack
        n_cmp++; if ({m_ack_o, m_err_o} !== 4'd0) begin n_fail++; $display("FAIL ab_late_ack: ack %b err %b want 0", m_ack_o, m_err_o); end
        n_cmp++; if (grant_o !== 2'b00 || m_stall_o !== 2'b11) begin n_fail++; $display("FAIL ab_idle: grant %b stall %b want 00 11", grant_o, m_stall_o); end
        step();
        s_ack_i[3] = 1'b0;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        @(negedge wb_clk_i);   // IDLE
        step();
        @(negedge wb_clk_i);   // GRANT: accept
        step();
        m_stb_i[0] = 1'b0;
        @(negedge wb_clk_i);   // WAIT
        n_cmp++; if (grant_o !== 2'b01 || s_cyc_o !== 5'b01000) begin n_fail++; $display("FAIL rs_pre: grant %b cyc %b want 01 01000", grant_o, s_cyc_o); end
        #1 wb_rst_i = 1'b1;
        #1;
        n_cmp++; if (grant_o !== 2'b00 || m_stall_o !== 2'b11) begin n_fail++; $display("FAIL rs_async_grant: grant %b stall %b want 00 11", grant_o, m_stall_o); end
        n_cmp++; if ({s_cyc_o, s_adr_o} !== 37'd0) begin n_fail++; $display("FAIL rs_async_slave: cyc %b adr %h want 0", s_cyc_o, s_adr_o); end
        clear_inputs();
        step();
        wb_rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_unmapped();
        test_timeout();
        test_stall_ack_err();
        test_abort_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_crossbar_rr.md
Name: wb_crossbar_rr

Overview:
Parametrised shared-bus Wishbone B4 pipelined interconnect connecting NUM_MASTERS masters (core instruction/data ports, future DMA) to NUM_SLAVES slaves. It adds round-robin arbitration and base/mask address decode. A built-in default slave errors unmapped addresses, and a response watchdog errors hung slaves. One transaction is outstanding at a time; responses are routed from the registered slave select.

Parameters:
NUM_MASTERS, 2, number of master ports (1..8)
NUM_SLAVES, 5, number of slave ports (1..16)
SLAVE_BASE, all zero, flat NUM_SLAVES*32 base addresses; slave k occupies bits [32k+31:32k]
SLAVE_MASK, all zero, flat NUM_SLAVES*32 decode masks; hit_k = ((adr & MASK_k) == BASE_k)
TIMEOUT, 255, cycles in WAIT before the watchdog error (1..65535); 0 disables the watchdog

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
m_cyc_i  in  NUM_MASTERS  master cycle
m_stb_i  in  NUM_MASTERS  master strobe
m_we_i  in  NUM_MASTERS  master write enable
m_adr_i  in  32*NUM_MASTERS  master address
m_dat_i  in  32*NUM_MASTERS  master write data
m_sel_i  in  4*NUM_MASTERS  master byte selects
m_stall_o  out  NUM_MASTERS  stall to master
m_ack_o  out  NUM_MASTERS  ack to master
m_err_o  out  NUM_MASTERS  error to master
m_dat_o  out  32*NUM_MASTERS  read data to master
s_cyc_o  out  NUM_SLAVES  per-slave cycle
s_stb_o  out  NUM_SLAVES  per-slave strobe
s_we_o  out  1  shared write enable
s_adr_o  out  32  shared address
s_dat_o  out  32  shared write data
s_sel_o  out  4  shared byte selects
s_stall_i  in  NUM_SLAVES  slave stall
s_ack_i  in  NUM_SLAVES  slave ack
s_err_i  in  NUM_SLAVES  slave error
s_dat_i  in  32*NUM_SLAVES  slave read data
grant_o  out  NUM_MASTERS  one-hot current grant (status)
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async): state IDLE, grant 0, rr pointer 0, timer 0, selected-slave register 0, default flag 0. While reset is held and until a grant exists, all outputs are 0, except m_stall_o = all ones.
- FSM states: IDLE, GRANT, WAIT.
- IDLE:
  - Requesters are masters with m_cyc_i & m_stb_i.
  - Pick the first requester at or after rr pointer, circularly.
  - Register the grant and go to GRANT. Arbitration latency is 1 cycle.
  - No requesters: remain in IDLE.
- GRANT:
  - Shared s_we/adr/dat/sel mux from the granted master; all other masters see stall=1, ack=0, err=0.
  - Decode on the granted m_adr_i. On multiple hits, the lowest-index slave wins.
  - s_cyc_o[k] = m_cyc & hit_k; s_stb_o[k] = m_stb & hit_k.
  - Granted m_stall_o = s_stall_i[k].
  - Accept when stb & !stall: register k, clear timer, go to WAIT.
  - No hit with stb: accept immediately (stall=0), set default flag, go to WAIT.
  - m_cyc_i drops: go to IDLE; rr pointer = granted index + 1 mod NUM_MASTERS.
- WAIT:
  - Granted m_stall_o = 1; s_cyc_o[k] held, s_stb_o = 0.
  - s_ack_i[k] or s_err_i[k]: forward ack/err/dat combinationally in the same cycle. Go to GRANT if m_cyc_i is still high, else IDLE.
  - ack and err together: err wins, ack suppressed.
  - Default flag: m_err_o pulses on the first WAIT cycle, then return.
  - Timer increments each WAIT cycle. At timer == TIMEOUT-1 with no response: m_err_o=1, timeout_o=1, s_cyc_o[k] drops next cycle, return.
  - Master drops m_cyc_i in WAIT: abort, drop s_cyc_o, go to IDLE. A late slave ack is discarded, never forwarded.
- Responses from non-selected slaves are ignored.
- m_dat_o of a non-granted master is 0.
- The grant is held for the whole master cycle, so a burst is not interleaved. Re-arbitration happens only via IDLE.
- Single-master configuration: rr pointer is stuck at 0; behaviour otherwise identical.

Test Plan:
- M0 single read at 0x0000_8010, slave 3 (base 0x8010, mask 0xFFFF_FFFC) acks with 0xA5A5_0001 2 cycles after accept -> m_ack_o[0] for 1 cycle, m_dat_o[0]=0xA5A5_0001; s_stb_o[3] high exactly 1 cycle; no other s_cyc_o set.
- M0 and M1 both request from reset, each doing 1 access and dropping cyc -> grant order M0, M1, M0, M1 across 4 rounds; grant_o one-hot.
- M1 writes 0x1234_5678, sel=0b0011, to unmapped 0xFFFF_0000 -> accept with no stall; m_err_o[1]=1 the next cycle; all s_stb_o stay 0.
- TIMEOUT=8, slave 2 never acks -> m_err_o and timeout_o pulse 8 cycles after accept; s_cyc_o[2] drops; a later M0 request is granted.
- Slave stalls 3 cycles, then accepts, then asserts ack and err together -> m_stall_o=1 for 3 cycles; only m_err_o is seen.
- M0 drops cyc in WAIT; slave acks 2 cycles later -> no m_ack_o; FSM in IDLE; wb_rst_i asserted mid-WAIT -> all outputs reset immediately, without waiting for a clock edge.
